// File: rtl/stack_queue_pkg.sv
// Shared constants and address helper for the stack/queue buffer.
// Pure definitions; no state, no latency, no flow control.
package stack_queue_pkg;

  localparam logic SQ_STACK = 1'b0;
  localparam logic SQ_QUEUE = 1'b1;

  // Wrapped peek slot: stack counts down from the newest entry, queue counts up from the oldest.
  function automatic logic [31:0] peekAddr(
    input logic [31:0] head,
    input logic [31:0] base,
    input logic [31:0] idx,
    input logic        mode,
    input logic [31:0] mask
  );
    if (mode == SQ_STACK) return (head - 32'd1 - idx) & mask;
    return (base + idx) & mask;
  endfunction

endpackage

// File: rtl/sq_ram.sv
// DEPTH x DATA_W storage with one synchronous write port and three asynchronous read ports.
// Latency: write visible one cycle after the edge, reads are combinational; no backpressure.
module sq_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic [ADDR_W-1:0] rdAddrC,
  output logic [DATA_W-1:0] rdDataC
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdDataA = mem[rdAddrA];
  assign rdDataB = mem[rdAddrB];
  assign rdDataC = mem[rdAddrC];

endmodule

// File: rtl/stack_queue_buffer.sv
// Circular LIFO/FIFO operand store with peek, flush and sticky over/underflow flags; STACK_QUEUE_WATERMARK_EN adds almost_full/almost_empty.
// Latency: outputs combinational from registered state (push visible next cycle); refused push/pop only raise a flag.
module stack_queue_buffer
  import stack_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
`ifdef STACK_QUEUE_WATERMARK_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] peek_idx,
  output logic [DATA_W-1:0] stack_out,
  output logic [DATA_W-1:0] queue_out,
  output logic [DATA_W-1:0] peek_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              unf_err
`ifdef STACK_QUEUE_WATERMARK_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] head, base, headNext, baseNext, wrAddr, topAddr, peekAddrQ;
  logic [ADDR_W:0]   countNext;
  logic              wrEn, ovfSet, unfSet;
  logic [31:0]       peekWide;
  logic              unusedPeekBits;
  logic [DATA_W-1:0] topData, baseData, peekData;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  always_comb begin
    headNext  = head;
    baseNext  = base;
    countNext = count;
    wrEn      = 1'b0;
    wrAddr    = head;
    ovfSet    = 1'b0;
    unfSet    = 1'b0;
    if (flush) begin
      headNext  = '0;
      baseNext  = '0;
      countNext = '0;
    end else if (push && pop) begin
      wrEn = 1'b1;
      if (empty) begin
        headNext  = head + PTR_ONE;
        countNext = count + CNT_ONE;
        unfSet    = 1'b1;
      end else if (mode == SQ_QUEUE) begin
        headNext = head + PTR_ONE;
        baseNext = base + PTR_ONE;
      end else begin
        // Stack replace-top: overwrite the newest slot in place.
        wrAddr = head - PTR_ONE;
      end
    end else if (push) begin
      if (full) begin
        ovfSet = 1'b1;
      end else begin
        wrEn      = 1'b1;
        headNext  = head + PTR_ONE;
        countNext = count + CNT_ONE;
      end
    end else if (pop) begin
      if (empty) begin
        unfSet = 1'b1;
      end else begin
        countNext = count - CNT_ONE;
        if (mode == SQ_QUEUE) baseNext = base + PTR_ONE;
        else                  headNext = head - PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      base    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      head    <= headNext;
      base    <= baseNext;
      count   <= countNext;
      ovf_err <= ovfSet | (ovf_err & ~err_clr);
      unf_err <= unfSet | (unf_err & ~err_clr);
    end
  end

`ifdef STACK_QUEUE_WATERMARK_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (countNext >= AF_CNT);
      almost_empty <= (countNext <= AE_CNT);
    end
  end
`endif

  assign topAddr        = head - PTR_ONE;
  assign peekWide       = peekAddr(32'(head), 32'(base), 32'(peek_idx), mode, 32'(DEPTH - 1));
  assign peekAddrQ      = peekWide[ADDR_W-1:0];
  assign unusedPeekBits = ^peekWide[31:ADDR_W];

  sq_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uRam (
    .clk     (clk),
    .wrEn    (wrEn & ~rst),
    .wrAddr  (wrAddr),
    .wrData  (data_in),
    .rdAddrA (topAddr),
    .rdDataA (topData),
    .rdAddrB (base),
    .rdDataB (baseData),
    .rdAddrC (peekAddrQ),
    .rdDataC (peekData)
  );

  // Memory is never reset, so every read is gated by occupancy.
  assign stack_out = empty ? '0 : topData;
  assign queue_out = empty ? '0 : baseData;
  assign peek_out  = ({1'b0, peek_idx} < count) ? peekData : '0;

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Directed bench for stack_queue_buffer: a DEPTH=4 instance for the main checks and a DEPTH=8 instance for mid-stream reset.
module tb_stack_queue_buffer;

  logic       clk = 1'b0;
  logic       rst, mode, push, pop, flush, err_clr;
  logic [7:0] data_in;
  logic [1:0] peek4;
  logic [2:0] peek8;

  logic [7:0] stk4, que4, pk4, stk8, que8, pk8;
  logic [2:0] cnt4;
  logic [3:0] cnt8;
  logic       emp4, ful4, ovf4, unf4, emp8, ful8, ovf8, unf8;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  stack_queue_buffer #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .peek_idx(peek4),
    .stack_out(stk4), .queue_out(que4), .peek_out(pk4), .count(cnt4),
    .empty(emp4), .full(ful4), .ovf_err(ovf4), .unf_err(unf4)
  );

  stack_queue_buffer #(.DATA_W(8), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .peek_idx(peek8),
    .stack_out(stk8), .queue_out(que8), .peek_out(pk8), .count(cnt8),
    .empty(emp8), .full(ful8), .ovf_err(ovf8), .unf_err(unf8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock with the given controls; controls drop back to idle afterwards.
  task automatic cyc(input logic m, input logic pu, input logic po, input logic [7:0] d);
    mode = m; push = pu; pop = po; data_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    cyc(mode, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic doClr();
    err_clr = 1'b1;
    cyc(mode, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    err_clr = 1'b0; data_in = 8'h00; peek4 = 2'd0; peek8 = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_stack", 32'(stk4), 32'h0);
    chk("rst_queue", 32'(que4), 32'h0);
    chk("rst_peek",  32'(pk4),  32'h0);
    chk("rst_count", 32'(cnt4), 32'd0);
    chk("rst_empty", 32'(emp4), 32'd1);
    chk("rst_full",  32'(ful4), 32'd0);
    chk("rst_flags", 32'({ovf4, unf4}), 32'd0);

    // Stack basics
    cyc(1'b0, 1'b1, 1'b0, 8'h0A);
    cyc(1'b0, 1'b1, 1'b0, 8'h0B);
    cyc(1'b0, 1'b1, 1'b0, 8'h0C);
    chk("stk_top",   32'(stk4), 32'h0C);
    chk("stk_base",  32'(que4), 32'h0A);
    chk("stk_count", 32'(cnt4), 32'd3);
    peek4 = 2'd1; #1;
    chk("stk_peek1", 32'(pk4), 32'h0B);
    peek4 = 2'd3; #1;
    chk("stk_peek_oob", 32'(pk4), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("stk_pop_top",   32'(stk4), 32'h0B);
    chk("stk_pop_count", 32'(cnt4), 32'd2);

    // Queue fill, overflow, wrap
    doFlush();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
    chk("q_full",  32'(ful4), 32'd1);
    chk("q_count", 32'(cnt4), 32'd4);
    cyc(1'b1, 1'b1, 1'b0, 8'h05);
    chk("q_ovf",       32'(ovf4), 32'd1);
    chk("q_ovf_count", 32'(cnt4), 32'd4);
    chk("q_ovf_head",  32'(que4), 32'h01);
    chk("q_ovf_tail",  32'(stk4), 32'h04);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("q_pop2_head", 32'(que4), 32'h03);
    cyc(1'b1, 1'b1, 1'b0, 8'h06);
    cyc(1'b1, 1'b1, 1'b0, 8'h07);
    chk("q_wrap_head", 32'(que4), 32'h03);
    chk("q_wrap_cnt",  32'(cnt4), 32'd4);
    peek4 = 2'd3; #1;
    chk("q_wrap_peek3", 32'(pk4), 32'h07);

    // Simultaneous push+pop on a full queue
    doFlush();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b1, 1'b1, 8'h09);
    chk("qpp_count", 32'(cnt4), 32'd4);
    chk("qpp_head",  32'(que4), 32'h02);
    chk("qpp_last",  32'(pk4),  32'h09);
    chk("qpp_full",  32'(ful4), 32'd1);

    // Stack replace-top
    doFlush();
    cyc(1'b0, 1'b1, 1'b0, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 8'h44);
    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    chk("srep_top",   32'(stk4), 32'h55);
    chk("srep_count", 32'(cnt4), 32'd2);
    peek4 = 2'd1; #1;
    chk("srep_below", 32'(pk4), 32'h33);

    // Underflow and flag handling; ovf survived the flushes
    doFlush();
    chk("ovf_sticky", 32'(ovf4), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_set",   32'(unf4), 32'd1);
    chk("unf_count", 32'(cnt4), 32'd0);
    doClr();
    chk("clr_flags", 32'({ovf4, unf4}), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'h77);
    chk("pp_empty_count", 32'(cnt4), 32'd1);
    chk("pp_empty_unf",   32'(unf4), 32'd1);
    chk("pp_empty_top",   32'(stk4), 32'h77);
    doClr();
    chk("clr_unf", 32'(unf4), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_vs_new_err", 32'(unf4), 32'd1);

    // Mode switch with contents present
    doFlush();
    doClr();
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("sw_q_head",  32'(que4), 32'h02);
    chk("sw_q_count", 32'(cnt4), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sw_s_top",   32'(stk4), 32'h02);
    chk("sw_s_count", 32'(cnt4), 32'd1);

    // Flush beats push
    flush = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("fl_count", 32'(cnt4), 32'd0);
    chk("fl_empty", 32'(emp4), 32'd1);
    chk("fl_top",   32'(stk4), 32'h0);

    // Mid-stream reset on the deeper instance
    doFlush();
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
    chk("d8_count", 32'(cnt8), 32'd5);
    chk("d8_top",   32'(stk8), 32'h05);
    peek8 = 3'd4; #1;
    chk("d8_peek4", 32'(pk8), 32'h01);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    chk("d8_rst_count", 32'(cnt8), 32'd0);
    chk("d8_rst_outs",  32'({stk8, que8, pk8}), 32'h0);
    chk("d8_rst_stat",  32'({emp8, ful8, ovf8, unf8}), 32'b1000);
    chk("d4_rst_ovf",   32'(ovf4), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d done", nPass, nChecks);
    $fatal(1);
  end

endmodule

// File: doc/stack_queue_buffer.md
Name: stack_queue_buffer

Overview:
- Parametrised successor to the calculator's 32x32 stack/queue store: circular buffer with DATA_W-bit entries and DEPTH slots.
- Runtime LIFO/FIFO mode, simultaneous push+pop, indexed peek, explicit flush, sticky over/underflow flags.
- Sits between the operand/command front end and the ALU sequencer; feeds both top-of-stack and head-of-queue.

Parameters:
- DATA_W, 32, entry width in bits.
- DEPTH, 32, slot count; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = stack (LIFO), 1 = queue (FIFO); sampled every cycle.
- push  in  1  write data_in this cycle.
- pop  in  1  remove one entry from the mode-selected end.
- flush  in  1  discard all contents.
- err_clr  in  1  clear sticky error flags.
- data_in  in  DATA_W  write data.
- peek_idx  in  ADDR_W  depth of entry to peek, counted from the pop end (0 = next to pop).
- stack_out  out  DATA_W  newest entry, mem[head-1]; 0 when empty.
- queue_out  out  DATA_W  oldest entry, mem[base]; 0 when empty.
- peek_out  out  DATA_W  entry at peek_idx; 0 when peek_idx >= count.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf_err  out  1  sticky: push refused while full.
- unf_err  out  1  sticky: pop refused while empty.

Behaviour:
- State: head (next write slot), base (oldest slot), count, ovf_err, unf_err. Pointers wrap modulo DEPTH.
- Reset (rst=1 at posedge): head=0, base=0, count=0, ovf_err=0, unf_err=0.
  - Outputs after reset: stack_out, queue_out and peek_out = 0; empty=1, full=0.
  - Memory array is not reset. All outputs are gated by count, so stale data is never visible.
- Read outputs are combinational from registered state: zero latency, and a pushed value is visible the cycle after the push edge.
- Priority per cycle: rst > flush > push/pop.
- flush: head=0, base=0, count=0; push/pop that cycle are ignored. Error flags are unaffected.
- push only:
  - Not full: mem[head] <= data_in; head+1; count+1.
  - Full: no change; ovf_err <= 1.
- pop only:
  - Not empty, stack mode: head-1; count-1.
  - Not empty, queue mode: base+1; count-1.
  - Empty: no change; unf_err <= 1.
- push and pop together:
  - Queue, not empty: write at head, head+1, base+1, count unchanged. Legal when full.
  - Stack, not empty: replace top. mem[head-1] <= data_in; pointers and count unchanged. Legal when full.
  - Empty, either mode: push performed, pop refused, unf_err <= 1.
- peek_out:
  - Stack mode: mem[head-1-peek_idx].
  - Queue mode: mem[base+peek_idx].
  - Index arithmetic is modulo DEPTH; result is 0 when peek_idx >= count.
- Mode change with data present: contents are preserved. Subsequent pops take from the new end.
- err_clr clears both flags. A same-cycle new error wins, leaving the flag at 1.
- All pointer and count arithmetic is done at declared widths; no wrap of count beyond DEPTH is possible.

Optional Feature:
- Macro: STACK_QUEUE_WATERMARK_EN.
- Defined:
  - Adds parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).
  - Both outputs are updated from next-state count so they align with count. Reset values: almost_full=0, almost_empty=1.
- Undefined: parameters and ports are absent; the remaining behaviour is identical.

Decomposition:
- Package stack_queue_pkg holds:
  - mode constants SQ_STACK=1'b0 and SQ_QUEUE=1'b1;
  - a function computing the wrapped peek address from (head, base, idx, mode).
- One sub-module, sq_ram: DEPTH x DATA_W, one synchronous write port and two asynchronous read ports (top/head, peek). queue_out uses a third read, or sq_ram exposes three.
- Pointer/count control stays in the top module.

Test Plan:
- Reset then push 0xA, 0xB, 0xC in stack mode -> stack_out=0xC, queue_out=0xA, count=3. Pop -> stack_out=0xB, count=2.
- Queue mode, DEPTH=4: push 1..4 -> full=1. Push 5 -> ovf_err=1, contents unchanged. Pop x2, push 6, 7 -> head wraps, queue_out=3, peek_idx=3 gives 7.
- Full queue with push 9 and pop together -> count stays 4, queue_out advances 1->2, 9 is stored last. In stack mode, push 0x55 + pop on a top of 0x44 -> stack_out=0x55, count unchanged.
- Empty with pop -> unf_err=1, count=0. Push + pop on empty -> count=1, unf_err=1. err_clr -> flags 0.
- Push 1, 2, 3 in stack mode, switch to queue, pop -> removes 1. Switch back to stack, pop -> removes 3, count=1.
- flush asserted with push in the same cycle -> count=0, empty=1, push ignored. rst mid-stream with count=5 -> all outputs return to reset values on the next edge.
